// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared state encodings and stage-control constants for the pipeline controller
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_LU   = 2'd1,
        ST_MC   = 2'd2,
        ST_TRAP = 2'd3
    } pipe_state_e;

    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic id_ex_we;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_RUN      = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam stage_ctrl_t CTRL_RESET    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    // Load-use keeps id_ex_we high so the bubble is actually clocked into ID/EX.
    localparam stage_ctrl_t CTRL_LU       = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam stage_ctrl_t CTRL_MC       = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam stage_ctrl_t CTRL_REDIRECT = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam stage_ctrl_t CTRL_TRAP     = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

endpackage

// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - request/control bundle between hazard sources and the pipeline controller
interface pipeline_ctrl_if;

    logic load_use_hz;
    logic br_taken;
    logic mc_start;
    logic mc_done;
    logic trap_req;

    logic pc_we;
    logic if_id_we;
    logic id_ex_we;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic mc_timeout;

    modport master (
        output load_use_hz, br_taken, mc_start, mc_done, trap_req,
        input  pc_we, if_id_we, id_ex_we, if_id_flush, id_ex_flush, ex_mem_flush, mc_timeout
    );

    modport slave (
        input  load_use_hz, br_taken, mc_start, mc_done, trap_req,
        output pc_we, if_id_we, id_ex_we, if_id_flush, id_ex_flush, ex_mem_flush, mc_timeout
    );

endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// rtl/pipeline_ctrl_sat_counter.sv - saturating up-counter used for pipeline perf statistics
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && !(&cnt)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
// Optional perf counters built only when PIPE_CTRL_PERF_EN is defined.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int LU_STALL_CYC = 1,
    parameter int MC_TIMEOUT   = 64,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    pipeline_ctrl_if.slave   bus,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int         MC_W    = $clog2(MC_TIMEOUT);
    localparam logic [2:0] LU_INIT = 3'(LU_STALL_CYC - 1);
    localparam logic [MC_W-1:0] MC_LAST = MC_W'(MC_TIMEOUT - 1);

    pipe_state_e     state, state_nxt;
    logic [2:0]      lu_cnt, lu_cnt_nxt;
    logic [MC_W-1:0] mc_cnt, mc_cnt_nxt;
    stage_ctrl_t     ctrl, ctrl_o;
    logic            timeout, timeout_o;

    always_comb begin
        ctrl       = CTRL_RUN;
        state_nxt  = state;
        lu_cnt_nxt = lu_cnt;
        mc_cnt_nxt = mc_cnt;
        timeout    = 1'b0;

        // Priority chain: trap, then the trap's second flush cycle, then branch redirect.
        if (bus.trap_req) begin
            ctrl      = CTRL_TRAP;
            state_nxt = ST_TRAP;
        end else if (state == ST_TRAP) begin
            ctrl      = CTRL_REDIRECT;
            state_nxt = ST_RUN;
        end else if (bus.br_taken) begin
            ctrl      = CTRL_REDIRECT;
            state_nxt = ST_RUN;
        end else begin
            case (state)
                ST_MC: begin
                    if (bus.mc_done) begin
                        state_nxt = ST_RUN;
                    end else begin
                        ctrl       = CTRL_MC;
                        mc_cnt_nxt = mc_cnt + MC_W'(1);
                        if (mc_cnt == MC_LAST) begin
                            timeout   = 1'b1;
                            state_nxt = ST_RUN;
                        end
                    end
                end
                ST_LU: begin
                    ctrl       = CTRL_LU;
                    lu_cnt_nxt = lu_cnt - 3'd1;
                    if (lu_cnt == 3'd1) begin
                        state_nxt = ST_RUN;
                    end
                end
                default: begin
                    // A multi-cycle issue outranks a load-use hazard seen in the same cycle.
                    if (bus.mc_start) begin
                        if (!bus.mc_done) begin
                            state_nxt  = ST_MC;
                            mc_cnt_nxt = '0;
                        end
                    end else if (bus.load_use_hz) begin
                        ctrl = CTRL_LU;
                        if (LU_STALL_CYC > 1) begin
                            state_nxt  = ST_LU;
                            lu_cnt_nxt = LU_INIT;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_RUN;
            lu_cnt <= '0;
            mc_cnt <= '0;
        end else begin
            state  <= state_nxt;
            lu_cnt <= lu_cnt_nxt;
            mc_cnt <= mc_cnt_nxt;
        end
    end

    // Hold every stage frozen and flushed while reset is asserted.
    assign ctrl_o    = rst_n ? ctrl : CTRL_RESET;
    assign timeout_o = rst_n & timeout;

    assign bus.pc_we        = ctrl_o.pc_we;
    assign bus.if_id_we     = ctrl_o.if_id_we;
    assign bus.id_ex_we     = ctrl_o.id_ex_we;
    assign bus.if_id_flush  = ctrl_o.if_id_flush;
    assign bus.id_ex_flush  = ctrl_o.id_ex_flush;
    assign bus.ex_mem_flush = ctrl_o.ex_mem_flush;
    assign bus.mc_timeout   = timeout_o;

`ifdef PIPE_CTRL_PERF_EN
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (~ctrl_o.pc_we),
        .cnt   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ctrl_o.if_id_flush | ctrl_o.id_ex_flush | ctrl_o.ex_mem_flush),
        .cnt   (flush_cnt)
    );
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed plus randomized check of pipeline_ctrl against a cycle model
module tb_pipeline_ctrl;

    localparam int LU  = 2;
    localparam int MCT = 4;
    localparam int CW  = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;

    always #5 clk = ~clk;

    pipeline_ctrl_if bus ();

    pipeline_ctrl #(
        .LU_STALL_CYC (LU),
        .MC_TIMEOUT   (MCT),
        .CNT_W        (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    int errors = 0;
    int checks = 0;

    // Model state: remaining load-use stall cycles, multi-cycle wait age, pending trap flush.
    int      lu_left;
    int      mc_age;
    bit      mc_wait;
    bit      in_trap;
    longint  exp_stall;
    longint  exp_flush;

    // Vector order: {pc_we, if_id_we, id_ex_we, if_id_flush, id_ex_flush, ex_mem_flush, mc_timeout}
    localparam logic [6:0] E_RUN  = 7'b1110000;
    localparam logic [6:0] E_RST  = 7'b0001110;
    localparam logic [6:0] E_LU   = 7'b0010100;
    localparam logic [6:0] E_MC   = 7'b0000010;
    localparam logic [6:0] E_TO   = 7'b0000011;
    localparam logic [6:0] E_REDR = 7'b1111100;
    localparam logic [6:0] E_TRAP = 7'b1111110;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] observed();
        return {bus.pc_we, bus.if_id_we, bus.id_ex_we, bus.if_id_flush,
                bus.id_ex_flush, bus.ex_mem_flush, bus.mc_timeout};
    endfunction

    task automatic model_reset();
        lu_left   = 0;
        mc_age    = 0;
        mc_wait   = 1'b0;
        in_trap   = 1'b0;
        exp_stall = 0;
        exp_flush = 0;
    endtask

    task automatic check_counters(input string tag);
`ifdef PIPE_CTRL_PERF_EN
        check({tag, "_stall_cnt"}, stall_cnt, 32'(exp_stall));
        check({tag, "_flush_cnt"}, flush_cnt, 32'(exp_flush));
`else
        check({tag, "_stall_cnt"}, stall_cnt, 32'd0);
        check({tag, "_flush_cnt"}, flush_cnt, 32'd0);
`endif
    endtask

    // Entered just after a rising edge; drives, checks at the falling edge, advances one cycle.
    task automatic step(input bit lu, input bit br, input bit ms, input bit md, input bit tr,
                        input string tag);
        logic [6:0] e;
        int  n_lu, n_age;
        bit  n_mc, n_trap;
        bus.load_use_hz = lu;
        bus.br_taken    = br;
        bus.mc_start    = ms;
        bus.mc_done     = md;
        bus.trap_req    = tr;
        n_lu = lu_left; n_age = mc_age; n_mc = mc_wait; n_trap = 1'b0;
        if (tr) begin
            e = E_TRAP; n_trap = 1'b1; n_mc = 1'b0; n_lu = 0;
        end else if (in_trap || br) begin
            e = E_REDR; n_mc = 1'b0; n_lu = 0;
        end else if (mc_wait) begin
            if (md) begin
                e = E_RUN; n_mc = 1'b0;
            end else if (mc_age == MCT - 1) begin
                e = E_TO; n_mc = 1'b0;
            end else begin
                e = E_MC; n_age = mc_age + 1;
            end
        end else if (lu_left > 0) begin
            e = E_LU; n_lu = lu_left - 1;
        end else if (ms) begin
            e = E_RUN;
            if (!md) begin
                n_mc = 1'b1; n_age = 0;
            end
        end else if (lu) begin
            e = E_LU; n_lu = LU - 1;
        end else begin
            e = E_RUN;
        end
        #4;
        check(tag, 32'(observed()), 32'(e));
        if (!e[6]) exp_stall++;
        if (|e[3:1]) exp_flush++;
        @(posedge clk);
        lu_left = n_lu; mc_age = n_age; mc_wait = n_mc; in_trap = n_trap;
        #1;
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, tag);
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.load_use_hz = 1'b0;
        bus.br_taken    = 1'b0;
        bus.mc_start    = 1'b0;
        bus.mc_done     = 1'b0;
        bus.trap_req    = 1'b0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("reset_ctl", 32'(observed()), 32'(E_RST));
        bus.trap_req = 1'b1;
        bus.mc_start = 1'b1;
        #1;
        check("reset_ctl_req", 32'(observed()), 32'(E_RST));
        check_counters("reset");
        bus.trap_req = 1'b0;
        bus.mc_start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0, "post_reset");
        idle(8, "idle");

        step(1, 0, 0, 0, 0, "lu_first");
        step(0, 0, 0, 0, 0, "lu_second");
        step(1, 0, 0, 0, 0, "lu_after");
        idle(3, "lu_tail");

        step(0, 0, 1, 0, 0, "mc_issue");
        idle(3, "mc_wait");
        step(0, 0, 0, 1, 0, "mc_done");
        idle(1, "mc_tail");

        step(0, 0, 1, 0, 0, "to_issue");
        idle(3, "to_wait");
        step(0, 0, 0, 0, 0, "to_pulse");
        idle(2, "to_tail");

        step(0, 0, 1, 1, 0, "mc_zero_wait");
        step(1, 1, 0, 0, 0, "lu_br");
        idle(2, "lu_br_tail");

        step(1, 0, 0, 0, 0, "lu_cancel_a");
        step(0, 1, 0, 0, 0, "lu_cancel_br");
        idle(1, "lu_cancel_tail");

        step(0, 0, 1, 0, 0, "trap_issue");
        step(0, 0, 0, 0, 0, "trap_mcwait");
        step(0, 0, 0, 1, 1, "trap_req");
        step(1, 1, 0, 0, 0, "trap_flush");
        idle(2, "trap_tail");
        check_counters("directed");

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(3) == 0, $urandom_range(7) == 0, $urandom_range(5) == 0,
                 $urandom_range(3) == 0, $urandom_range(19) == 0, "random");
        end
        check_counters("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
